// File: rtl/uart_frame_rx.sv
// Deframer behind the UART receive FIFO: hunts SOF, buffers LEN payload bytes,
// checks the XOR checksum and streams only verified payloads out on valid/ready.
module uart_frame_rx #(
    parameter int                  DATA_BITS      = 8,
    parameter int                  MAX_LEN        = 16,
    parameter logic [DATA_BITS-1:0] SOF           = 8'hA5,
    parameter int                  TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_empty,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_uart,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_last,
    input  logic                 m_ready,
    output logic                 frame_ok,
    output logic                 err_chk,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic                 busy
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        len_q, len_d;
    logic [IW-1:0]        wr_idx_q, wr_idx_d;
    logic [IW-1:0]        rd_idx_q, rd_idx_d;
    logic [DATA_BITS-1:0] chk_q, chk_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 frame_ok_q, frame_ok_d;
    logic                 err_chk_q, err_chk_d;
    logic                 err_len_q, err_len_d;
    logic                 err_tmo_q, err_tmo_d;
    logic                 wr_en;
    logic                 pop;
    logic                 len_legal;
    logic [DATA_BITS-1:0] pbuf_q [MAX_LEN];

    assign pop       = rd_uart;
    assign len_legal = (rd_data != '0) && (rd_data <= DATA_BITS'(MAX_LEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            chk_q      <= '0;
            tmo_q      <= '0;
            frame_ok_q <= 1'b0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            chk_q      <= chk_d;
            tmo_q      <= tmo_d;
            frame_ok_q <= frame_ok_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

    // Payload storage needs no reset; stale contents are never read before rewrite.
    always_ff @(posedge clk) begin
        if (wr_en) pbuf_q[wr_idx_q[AW-1:0]] <= rd_data;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        chk_d      = chk_q;
        tmo_d      = tmo_q;
        frame_ok_d = 1'b0;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        err_tmo_d  = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop && rd_data == SOF) begin
                    state_d = LEN;
                    chk_d   = '0;
                    tmo_d   = '0;
                end
            end
            LEN: begin
                if (pop) begin
                    tmo_d = '0;
                    if (len_legal) begin
                        len_d    = IW'(rd_data);
                        chk_d    = rd_data;
                        wr_idx_d = '0;
                        state_d  = PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    tmo_d    = '0;
                    wr_en    = 1'b1;
                    chk_d    = chk_q ^ rd_data;
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (wr_idx_q == len_q - IW'(1)) state_d = CHK;
                end
            end
            CHK: begin
                if (pop) begin
                    tmo_d = '0;
                    if (rd_data == chk_q) begin
                        state_d    = DRAIN;
                        rd_idx_d   = '0;
                        frame_ok_d = 1'b1;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    if (rd_idx_q == len_q - IW'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Counter steps into TIMEOUT_CYCLES-1 here, so the pulse lands TIMEOUT_CYCLES after the last pop.
        if ((state_q == LEN || state_q == PAYLOAD || state_q == CHK) && !pop) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
                err_tmo_d = 1'b1;
                state_d   = IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_comb begin
        rd_uart     = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        m_data      = pbuf_q[rd_idx_q[AW-1:0]];
        busy        = (state_q != IDLE);
        frame_ok    = frame_ok_q;
        err_chk     = err_chk_q;
        err_len     = err_len_q;
        err_timeout = err_tmo_q;
        if (state_q == DRAIN) begin
            m_valid = 1'b1;
            m_last  = (rd_idx_q == len_q - IW'(1));
        end else begin
            rd_uart = ~rx_empty;
        end
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: a FIFO model feeds frames, a negedge
// monitor checks output bytes and status pulses against queued expectations.
module tb_uart_frame_rx;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       m_ready = 1'b0;
    logic       rd_uart, m_valid, m_last, frame_ok, err_chk, err_len, err_timeout, busy;
    logic [7:0] m_data;

    always #5 clk = ~clk;

    uart_frame_rx #(.DATA_BITS(8), .MAX_LEN(16), .SOF(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .rd_data(rd_data), .rd_uart(rd_uart),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .frame_ok(frame_ok), .err_chk(err_chk), .err_len(err_len),
        .err_timeout(err_timeout), .busy(busy)
    );

    logic [7:0] fifo[$];
    logic [8:0] exp_q[$];
    int         evt_q[$];
    int         cyc = 0, errors = 0, checks = 0;
    int         last_pop = 0, last_xfer = -1;
    bit         gap_arm = 0, bp_en = 0, rdy_cfg = 1;
    bit         stall_prev = 0;
    logic [8:0] prev_out = '0;
    logic [3:0] pat = 4'b1001;
    int         k = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // FIFO model: pop on the edge, present the new head shortly after.
    always @(posedge clk) begin
        cyc++;
        if (rd_uart && !rx_empty) void'(fifo.pop_front());
        #1;
        rx_empty = (fifo.size() == 0);
        rd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    always @(posedge clk) begin
        #2;
        if (bp_en) begin
            m_ready = pat[k];
            k = (k + 1) % 4;
        end else begin
            m_ready = rdy_cfg;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", {m_last, m_data});
                end else begin
                    chk("m_last_data", {m_last, m_data}, exp_q.pop_front());
                end
            end
            if (m_valid) chk("rd_uart_in_drain", rd_uart, 0);
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_hold", {m_last, m_data}, prev_out);
            end
            stall_prev = m_valid && !m_ready;
            prev_out   = {m_last, m_data};
            if (frame_ok || err_chk || err_len || err_timeout) begin
                int n, code;
                n    = int'(frame_ok) + int'(err_chk) + int'(err_len) + int'(err_timeout);
                code = frame_ok ? 1 : err_chk ? 2 : err_len ? 3 : 4;
                chk("pulse_onehot", n, 1);
                if (evt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: got %0d expected none", code);
                end else begin
                    chk("event", code, evt_q.pop_front());
                end
            end
            if (err_timeout) chk("tmo_delay", cyc - last_pop, TMO);
            if (m_valid && m_ready && m_last) last_xfer = cyc;
            if (rd_uart && !rx_empty) begin
                if (gap_arm && last_xfer >= 0) begin
                    chk("frame_gap", cyc, last_xfer + 1);
                    gap_arm = 0;
                end
                last_pop = cyc;
            end
        end
    end

    // Bytes are packed MSB-first: the first byte sent is the most significant.
    task automatic send(input int n, input logic [159:0] v);
        for (int i = 0; i < n; i++) fifo.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic exp_frame(input int n, input logic [127:0] p);
        for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), p[8*(n-1-i) +: 8]});
        evt_q.push_back(1);
    endtask

    task automatic wait_done(input string nm, input int lim);
        int n;
        n = 0;
        while ((fifo.size() != 0 || busy || exp_q.size() != 0 || evt_q.size() != 0) && n < lim) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= lim) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, fifo=%0d exp=%0d evt=%0d",
                     nm, n, fifo.size(), exp_q.size(), evt_q.size());
            fifo.delete(); exp_q.delete(); evt_q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 chk("reset_outs", {rd_uart, m_valid, m_last, frame_ok, err_chk, err_len, err_timeout, busy}, 0);
        reset = 1'b0;
        @(posedge clk);

        // good frame
        send(6, 48'hA5_03_11_22_33_03);
        exp_frame(3, 24'h11_22_33);
        wait_done("good_frame", 100);

        // bad checksum, then good frame
        send(6, 48'hA5_03_11_22_33_04);
        evt_q.push_back(2);
        send(6, 48'hA5_03_11_22_33_03);
        exp_frame(3, 24'h11_22_33);
        wait_done("bad_chk", 100);

        // garbage, length errors, max-length frame
        send(3, 24'h00_FF_5A);
        send(6, 48'hA5_03_11_22_33_03);
        exp_frame(3, 24'h11_22_33);
        send(2, 16'hA5_00);
        evt_q.push_back(3);
        send(2, 16'hA5_11);
        evt_q.push_back(3);
        send(19, {8'hA5, 8'h10, 128'h0102030405060708090A0B0C0D0E0F10, 8'h00});
        exp_frame(16, 128'h0102030405060708090A0B0C0D0E0F10);
        wait_done("len_cases", 200);

        // inter-byte timeout, then single-byte frame
        send(3, 24'hA5_02_11);
        evt_q.push_back(4);
        wait_done("timeout", 200);
        chk("busy_after_tmo", busy, 0);
        send(4, 32'hA5_01_7E_7F);
        exp_frame(1, 8'h7E);
        wait_done("one_byte", 100);

        // backpressure with second frame queued behind the first
        last_xfer = -1;
        gap_arm   = 1;
        k         = 0;
        bp_en     = 1;
        send(6, 48'hA5_04_DE_AD_BE_EF);
        fifo.push_back(8'h26);
        send(5, 40'hA5_02_C3_3C_FD);
        exp_frame(4, 32'hDE_AD_BE_EF);
        exp_frame(2, 16'hC3_3C);
        wait_done("backpressure", 200);
        bp_en = 0;
        chk("gap_seen", gap_arm, 0);

        // reset during PAYLOAD
        send(4, 32'hA5_05_01_02);
        repeat (8) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("rst_payload", {rd_uart, m_valid, m_last, busy}, 0);
        fifo.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // reset during DRAIN while stalled
        rdy_cfg = 0;
        send(5, 40'hA5_02_55_AA_FD);
        evt_q.push_back(1);
        begin
            int n;
            n = 0;
            while (!m_valid && n < 50) begin @(negedge clk); n++; end
            chk("drain_reached", m_valid, 1);
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("rst_drain", {m_valid, m_last, frame_ok, err_chk, err_len, err_timeout, busy}, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        rdy_cfg = 1;
        chk("evt_after_rst", evt_q.size(), 0);

        send(5, 40'hA5_02_55_AA_FD);
        exp_frame(2, 16'h55_AA);
        wait_done("post_reset", 100);

        chk("exp_q_empty", exp_q.size(), 0);
        chk("evt_q_empty", evt_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Packet deframer directly downstream of the UART wrapper's receive FIFO.
- Pops bytes through the FIFO read handshake (rd_uart / rx_empty / rd_data).
- Hunts for a start-of-frame byte and collects length plus payload into an internal buffer, then verifies an XOR checksum.
- Releases only verified payloads on a valid/ready byte stream for the processor-side logic; bad frames are dropped with error pulses.

Parameters:
- DATA_BITS, 8, width of UART bytes and of the output stream.
- MAX_LEN, 16, maximum payload bytes per frame (legal LEN is 1..MAX_LEN).
- SOF, 8'hA5, start-of-frame byte value.
- TIMEOUT_CYCLES, 100000, clk cycles allowed between consecutive bytes inside a frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_empty  input  1  receive FIFO empty flag.
- rd_data  input  DATA_BITS  receive FIFO head byte; valid whenever rx_empty=0 (first-word fall-through).
- rd_uart  output  1  pop strobe to the receive FIFO.
- m_data  output  DATA_BITS  payload byte out.
- m_valid  output  1  m_data valid.
- m_last  output  1  marks the final payload byte of a frame.
- m_ready  input  1  consumer accepts the byte.
- frame_ok  output  1  one-cycle pulse when a frame passes its checksum.
- err_chk  output  1  one-cycle pulse on checksum mismatch.
- err_len  output  1  one-cycle pulse on illegal LEN.
- err_timeout  output  1  one-cycle pulse on inter-byte timeout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Frame format: SOF, LEN, LEN payload bytes, CHK.
  - CHK = LEN XOR payload[0] XOR ... XOR payload[LEN-1].
- Reset (async, any state, including mid-DRAIN):
  - State goes to IDLE; rd_uart, m_valid, m_last, frame_ok and all err_* are 0.
  - Counters and chk are 0; buffer contents are don't-care.
- rd_uart is combinational: rd_uart = ~rx_empty while in IDLE/LEN/PAYLOAD/CHK, 0 in DRAIN.
  - A byte is consumed in the same cycle rd_uart=1 and is sampled from rd_data in that cycle.
- IDLE:
  - A popped byte equal to SOF goes to LEN; chk clears to 0.
  - Any other byte is discarded silently and the state stays IDLE.
- LEN:
  - Popped byte in 1..MAX_LEN: store len, chk = byte, wr_idx = 0, go to PAYLOAD.
  - Byte of 0 or greater than MAX_LEN: err_len pulses next cycle and the state returns to IDLE. The byte is consumed and SOF is not re-checked.
- PAYLOAD:
  - Each pop writes buf[wr_idx] = byte, chk ^= byte, wr_idx++.
  - The pop with wr_idx == len-1 moves to CHK.
- CHK: the pop compares the byte with chk.
  - Equal: go to DRAIN with rd_idx = 0, and frame_ok pulses in the first DRAIN cycle.
  - Unequal: err_chk pulses next cycle and the state returns to IDLE; the buffer is discarded.
- DRAIN:
  - m_valid = 1, m_data = buf[rd_idx], m_last = (rd_idx == len-1).
  - A transfer happens when m_valid & m_ready; it increments rd_idx.
  - The transfer with m_last returns to IDLE, with m_valid = 0 the next cycle.
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - No FIFO reads occur in DRAIN; bytes arriving meanwhile wait in the FIFO.
- Latency: CHK popped in cycle N gives the first m_valid in cycle N+1. Minimum gap between frames is 1 cycle (IDLE).
- Timeout:
  - A counter clears on every pop and on entry to LEN.
  - It increments each cycle in LEN/PAYLOAD/CHK while no pop occurs.
  - On reaching TIMEOUT_CYCLES-1: err_timeout pulses next cycle, the state returns to IDLE and the partial frame is dropped.
  - The counter is idle in IDLE and DRAIN.
- Counter widths: idx/len are $clog2(MAX_LEN+1) bits; the timeout counter is $clog2(TIMEOUT_CYCLES) bits.
- At most one of frame_ok/err_* is high in any cycle; all are single-cycle registered pulses.

Test Plan:
1. Good frame: FIFO holds A5 03 11 22 33 03, m_ready=1 -> rd_uart pops 6 bytes; frame_ok pulses once; m_data 11,22,33 on consecutive cycles with m_last only on 33; no err_*.
2. Bad checksum: A5 03 11 22 33 04 -> err_chk pulse, m_valid never asserts; a following good frame (scenario 1 bytes) is delivered correctly.
3. Garbage and length errors, MAX_LEN=16:
   - 00 FF 5A before a good frame -> discarded silently, frame delivered.
   - A5 00 -> err_len.
   - A5 11 -> err_len.
   - A5 10 followed by 16 payload bytes plus correct CHK -> 16 bytes out, m_last on the 16th.
4. Timeout, TIMEOUT_CYCLES=64: A5 02 11 then FIFO stays empty -> err_timeout exactly 64 cycles after the last pop, busy drops. Then A5 01 7E 7F -> single byte 7E with m_last, frame_ok.
5. Backpressure and overlap: frame 1 in DRAIN with m_ready toggled 1,0,0,1,... while frame 2 bytes sit in the FIFO.
   - Expect m_data/m_last stable during stalls and rd_uart=0 throughout DRAIN.
   - Frame 2 pops start the cycle after the m_last transfer.
6. Reset mid-operation: assert reset during PAYLOAD and again during DRAIN -> outputs 0 immediately (async), busy=0. After release, a fresh good frame is delivered normally with no stale bytes.
